sram_axi_bridge: RTL and testbench

SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

---
 rtl/sram_axi_bridge.sv | 154 +++++++++++++++
 tb/tb_sram_axi_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_axi_bridge.sv
// Bridges the CPU's SRAM-style inst/data ports onto a single-beat AXI master.
// One read FSM (shared by inst and data) and one write FSM (data only).
module sram_axi_bridge #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [1:0]        inst_size,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [31:0]       inst_rdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_B} w_state_t;

    r_state_t          r_state;
    w_state_t          w_state;
    logic              r_inst_q;
    logic [ADDR_W-1:0] r_addr_q;
    logic [1:0]        r_size_q;
    logic [ADDR_W-1:0] w_addr_q;
    logic [1:0]        w_size_q;
    logic [31:0]       w_data_q;
    logic              aw_done_q;
    logic              w_done_q;

    logic r_idle;
    logic w_idle;
    logic r_fire;
    logic aw_fire;
    logic w_fire;

    always_comb begin
        r_idle  = (r_state == R_IDLE);
        w_idle  = (w_state == W_IDLE);
        // A data write may overlap an inst fetch; any other overlap would reorder data accesses.
        data_addr_ok = resetn & data_req & w_idle & (data_wr ? (r_idle | r_inst_q) : r_idle);
        inst_addr_ok = resetn & inst_req & r_idle & ~(data_req & ~data_wr);

        araddr  = r_addr_q;
        arsize  = {1'b0, r_size_q};
        arvalid = (r_state == R_AR);
        rready  = (r_state == R_R);
        r_fire  = (r_state == R_R) & rvalid;

        awaddr  = w_addr_q;
        awsize  = {1'b0, w_size_q};
        wdata   = w_data_q;
        awvalid = (w_state == W_REQ) & ~aw_done_q;
        wvalid  = (w_state == W_REQ) & ~w_done_q;
        bready  = (w_state == W_B);
        aw_fire = awvalid & awready;
        w_fire  = wvalid & wready;

        inst_rdata   = rdata;
        data_rdata   = rdata;
        inst_data_ok = r_fire & r_inst_q;
        data_data_ok = (r_fire & ~r_inst_q) | ((w_state == W_B) & bvalid);

        case (w_size_q)
            2'd0:    wstrb = 4'b0001 << w_addr_q[1:0];
            2'd1:    wstrb = w_addr_q[1] ? 4'b1100 : 4'b0011;
            default: wstrb = 4'b1111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= R_IDLE;
            r_inst_q <= 1'b0;
            r_addr_q <= '0;
            r_size_q <= 2'd0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (data_addr_ok && !data_wr) begin
                        r_state  <= R_AR;
                        r_inst_q <= 1'b0;
                        r_addr_q <= data_addr;
                        r_size_q <= data_size;
                    end else if (inst_addr_ok) begin
                        r_state  <= R_AR;
                        r_inst_q <= 1'b1;
                        r_addr_q <= inst_addr;
                        r_size_q <= inst_size;
                    end
                end
                R_AR:    if (arready) r_state <= R_R;
                R_R:     if (rvalid) r_state <= R_IDLE;
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            w_state   <= W_IDLE;
            w_addr_q  <= '0;
            w_size_q  <= 2'd0;
            w_data_q  <= 32'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (data_addr_ok && data_wr) begin
                        w_state   <= W_REQ;
                        w_addr_q  <= data_addr;
                        w_size_q  <= data_size;
                        w_data_q  <= data_wdata;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                W_REQ: begin
                    aw_done_q <= aw_done_q | aw_fire;
                    w_done_q  <= w_done_q | w_fire;
                    if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) w_state <= W_B;
                end
                W_B:     if (bvalid) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed and randomized bench for sram_axi_bridge; the bench itself plays the AXI slave.
module tb_sram_axi_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    int n_cmp = 0;
    int n_err = 0;

    sram_axi_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks run 2 units later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane mask of an access: 2^size contiguous bytes starting at the size-aligned lane.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [31:0] addr);
        int nbytes = 1 << size;
        int first  = int'(addr[1:0]) & ~(nbytes - 1);
        return 4'(((1 << nbytes) - 1) << first);
    endfunction

    // Called in the cycle after the read was accepted.
    task automatic serve_read(input logic is_inst, input logic [31:0] addr, input logic [1:0] size,
                              input int ar_d, input int r_d, input logic [31:0] rd);
        for (int c = 0; c <= ar_d; c++) begin
            arready = (c == ar_d);
            #2;
            chk("arvalid", 32'(arvalid), 32'd1);
            chk("araddr", araddr, addr);
            chk("arsize", 32'(arsize), 32'(size));
            chk("rready_ar", 32'(rready), 32'd0);
            chk("inst_addr_ok_busy", 32'(inst_addr_ok), 32'd0);
            step();
        end
        arready = 1'b0;
        for (int c = 0; c <= r_d; c++) begin
            rvalid = (c == r_d);
            rdata  = rd;
            #2;
            chk("rready", 32'(rready), 32'd1);
            chk("arvalid_r", 32'(arvalid), 32'd0);
            chk("inst_data_ok", 32'(inst_data_ok), 32'(is_inst && c == r_d));
            chk("data_data_ok_rd", 32'(data_data_ok), 32'(!is_inst && c == r_d));
            chk("inst_addr_ok_done", 32'(inst_addr_ok), 32'd0);
            if (c == r_d) chk(is_inst ? "inst_rdata" : "data_rdata",
                              is_inst ? inst_rdata : data_rdata, rd);
            step();
        end
        rvalid = 1'b0;
    endtask

    // Called while the write FSM is in its request phase.
    task automatic serve_write(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                               input int aw_d, input int w_d, input int b_d);
        int last = (aw_d > w_d) ? aw_d : w_d;
        for (int c = 0; c <= last; c++) begin
            awready = (c == aw_d);
            wready  = (c == w_d);
            #2;
            chk("awvalid", 32'(awvalid), 32'(c <= aw_d));
            chk("wvalid", 32'(wvalid), 32'(c <= w_d));
            if (c <= aw_d) begin
                chk("awaddr", awaddr, addr);
                chk("awsize", 32'(awsize), 32'(size));
            end
            if (c <= w_d) begin
                chk("wdata", wdata, wd);
                chk("wstrb", 32'(wstrb), 32'(lane_mask(size, addr)));
            end
            chk("bready_req", 32'(bready), 32'd0);
            step();
        end
        awready = 1'b0;
        wready  = 1'b0;
        for (int c = 0; c <= b_d; c++) begin
            bvalid = (c == b_d);
            #2;
            chk("bready", 32'(bready), 32'd1);
            chk("awvalid_b", 32'(awvalid), 32'd0);
            chk("data_data_ok_wr", 32'(data_data_ok), 32'(c == b_d));
            chk("data_addr_ok_b", 32'(data_addr_ok), 32'd0);
            step();
        end
        bvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        int          kind;

        resetn = 1'b0; inst_req = 1'b0; inst_size = 2'd2; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = '0; data_wdata = '0;
        arready = 1'b0; rdata = '0; rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        step();
        step();
        inst_req = 1'b1;
        #2;
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_awvalid", 32'(awvalid), 32'd0);
        chk("rst_wvalid", 32'(wvalid), 32'd0);
        chk("rst_bready", 32'(bready), 32'd0);
        chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        chk("rst_data_ok", 32'({inst_data_ok, data_data_ok}), 32'd0);
        inst_req = 1'b0;
        step();
        resetn = 1'b1;
        step();

        // Boot fetch with immediate arready and rvalid one cycle later.
        inst_req = 1'b1; inst_addr = 32'h1FC0_0000; inst_size = 2'd2;
        #2;
        chk("boot_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
        chk("boot_arvalid_T", 32'(arvalid), 32'd0);
        step();
        inst_req = 1'b0;
        serve_read(1'b1, 32'h1FC0_0000, 2'd2, 0, 0, 32'h3C01_0001);
        #2;
        chk("boot_idle_rready", 32'(rready), 32'd0);
        chk("boot_idle_data_ok", 32'(inst_data_ok), 32'd0);
        step();

        // Data read wins over a simultaneous fetch; the fetch waits for data_data_ok.
        inst_req = 1'b1; inst_addr = 32'h1FC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_1000; data_size = 2'd2;
        #2;
        chk("prio_data_addr_ok", 32'(data_addr_ok), 32'd1);
        chk("prio_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
        step();
        data_req = 1'b0;
        serve_read(1'b0, 32'h0000_1000, 2'd2, 1, 2, 32'hDEAD_BEEF);
        #2;
        chk("prio_inst_after", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0;
        serve_read(1'b1, 32'h1FC0_0004, 2'd2, 0, 1, 32'h2408_0005);

        // Byte store at lane 2: AW completes first, W two cycles later.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h0000_2002; data_wdata = 32'h00AB_0000;
        #2;
        chk("sb_data_addr_ok", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        serve_write(32'h0000_2002, 2'd0, 32'h00AB_0000, 0, 2, 1);

        // Fetches proceed under an outstanding write; a second data request waits.
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h0000_3000; data_wdata = 32'h1111_2222;
        #2;
        chk("ovl_w1_accept", 32'(data_addr_ok), 32'd1);
        step();
        data_addr = 32'h0000_3004; data_wdata = 32'h3333_4444;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0010;
        #2;
        chk("ovl_inst_accept", 32'(inst_addr_ok), 32'd1);
        chk("ovl_w2_held", 32'(data_addr_ok), 32'd0);
        step();
        inst_req = 1'b0;
        serve_read(1'b1, 32'h1FC0_0010, 2'd2, 1, 0, 32'h8C01_0000);
        #2;
        chk("ovl_w2_held_after_rd", 32'(data_addr_ok), 32'd0);
        serve_write(32'h0000_3000, 2'd2, 32'h1111_2222, 1, 0, 0);
        #2;
        chk("ovl_w2_accept", 32'(data_addr_ok), 32'd1);
        step();
        data_req = 1'b0;
        serve_write(32'h0000_3004, 2'd2, 32'h3333_4444, 0, 0, 2);

        // Reset while waiting for read data abandons the fetch.
        inst_req = 1'b1; inst_addr = 32'h1FC0_0020;
        #2;
        chk("rst_rr_accept", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0; arready = 1'b1;
        step();
        arready = 1'b0; resetn = 1'b0;
        #2;
        chk("rst_rr_rready_before", 32'(rready), 32'd1);
        step();
        resetn = 1'b1; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        #2;
        chk("rst_rr_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rr_rready", 32'(rready), 32'd0);
        chk("rst_rr_no_data_ok", 32'(inst_data_ok), 32'd0);
        step();
        rvalid = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1FC0_0024;
        #2;
        chk("rst_rr_reaccept", 32'(inst_addr_ok), 32'd1);
        step();
        inst_req = 1'b0;
        serve_read(1'b1, 32'h1FC0_0024, 2'd2, 0, 0, 32'h0000_0000);

        // Randomized single transactions with random slave latencies.
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            s    = 2'($urandom_range(0, 2));
            a    = $urandom;
            d    = $urandom;
            if (kind == 0) begin
                inst_req = 1'b1; inst_addr = a; inst_size = s;
                #2;
                chk("rnd_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
                chk("rnd_inst_data_addr_ok", 32'(data_addr_ok), 32'd0);
                step();
                inst_req = 1'b0;
                serve_read(1'b1, a, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
            end else if (kind == 1) begin
                inst_req = 1'($urandom_range(0, 1)); inst_addr = ~a;
                data_req = 1'b1; data_wr = 1'b0; data_addr = a; data_size = s;
                #2;
                chk("rnd_dr_addr_ok", 32'(data_addr_ok), 32'd1);
                chk("rnd_dr_inst_blocked", 32'(inst_addr_ok), 32'd0);
                step();
                data_req = 1'b0; inst_req = 1'b0;
                serve_read(1'b0, a, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), d);
            end else begin
                data_req = 1'b1; data_wr = 1'b1; data_addr = a; data_size = s; data_wdata = d;
                #2;
                chk("rnd_dw_addr_ok", 32'(data_addr_ok), 32'd1);
                step();
                data_req = 1'b0;
                serve_write(a, s, d, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                            int'($urandom_range(0, 3)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
